// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and monitor state encoding,
// used by both the VGA timing generator and the timing monitor.
package vga_timing_pkg;

  localparam int H_TOTAL_640 = 800;
  localparam int V_TOTAL_480 = 525;
  localparam int H_SYNC_640  = 96;
  localparam int V_SYNC_480  = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_timing_monitor_sync.sv
// sync_edge_detect: normalizes sync polarity to active-high, keeps a one-cycle
// registered copy and flags the leading edge of the active phase.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sync_i,
  output logic edge_o
);

  logic act;
  logic act_q;

  assign act = sync_i ^ ACTIVE_LOW;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) act_q <= 1'b0;
    else          act_q <= act;
  end

  assign edge_o = act & ~act_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Recovers x/y position from hsync/vsync and checks line/frame lengths, with lock tracking.
// Optional error statistics (err_count, clr_stats) are built when VGA_MON_STATS_EN is defined.
//
// state  | meaning
// SEARCH | no frame reference yet; lengths are not checked
// ALIGN  | frame origin seen; counting consecutive error-free frames
// LOCKED | LOCK_FRAMES clean frames seen; any error drops back to ALIGN
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL         = H_TOTAL_640,
  parameter int V_TOTAL         = V_TOTAL_480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2,
  parameter int TIMEOUT_MULT    = 2
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic        timeout
`ifdef VGA_MON_STATS_EN
  ,
  input  logic        clr_stats,
  output logic [15:0] err_count
`endif
);

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  // Compared against the current count so the pulse lines up with x_pos at the limit.
  localparam logic [15:0] TO_PRE = 16'(H_TOTAL * TIMEOUT_MULT - 2);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic h_edge, v_edge;

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
    .clk_i  (clk_25MHz),
    .rst_n_i(rst_n),
    .sync_i (hsync),
    .edge_o (h_edge)
  );

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
    .clk_i  (clk_25MHz),
    .rst_n_i(rst_n),
    .sync_i (vsync),
    .edge_o (v_edge)
  );

  logic [15:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic        v_pend_q, v_pend_d;
  logic        fs_q, fs_d, le_q, le_d, fe_q, fe_d, to_q, to_d;
  mon_state_e  state_q;
  logic [3:0]  good_q;
  logic        err_seen_q;
  logic        locked_q;

  always_comb begin
    x_pos_d  = sat_inc16(x_pos_q);
    y_pos_d  = y_pos_q;
    v_pend_d = v_pend_q;
    fs_d     = 1'b0;
    le_d     = 1'b0;
    fe_d     = 1'b0;
    to_d     = 1'b0;
    if (h_edge) begin
      x_pos_d = '0;
      le_d    = (state_q != SEARCH) && (x_pos_q != H_LAST);
      if (v_pend_q || v_edge) begin
        y_pos_d  = '0;
        fs_d     = 1'b1;
        fe_d     = (state_q != SEARCH) && (y_pos_q != V_LAST);
        v_pend_d = 1'b0;
      end else begin
        y_pos_d = sat_inc16(y_pos_q);
      end
    end else begin
      to_d = (x_pos_q == TO_PRE);
      if (v_edge) v_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_q  <= '0;
      y_pos_q  <= '0;
      v_pend_q <= 1'b0;
      fs_q     <= 1'b0;
      le_q     <= 1'b0;
      fe_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      x_pos_q  <= x_pos_d;
      y_pos_q  <= y_pos_d;
      v_pend_q <= v_pend_d;
      fs_q     <= fs_d;
      le_q     <= le_d;
      fe_q     <= fe_d;
      to_q     <= to_d;
    end
  end

  // err_seen_q marks an error since the last frame_start; that frame is not counted good.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      err_seen_q <= 1'b0;
      locked_q   <= 1'b0;
    end else if (to_d) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      err_seen_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (fs_d) begin
            state_q    <= ALIGN;
            good_q     <= '0;
            err_seen_q <= 1'b0;
          end
        end
        ALIGN: begin
          if (le_d || fe_d) begin
            good_q     <= '0;
            err_seen_q <= ~fs_d;
          end else if (fs_d) begin
            err_seen_q <= 1'b0;
            if (!err_seen_q) begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (le_d || fe_d) begin
            state_q    <= ALIGN;
            locked_q   <= 1'b0;
            good_q     <= '0;
            err_seen_q <= ~fs_d;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_MON_STATS_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n)                   err_count_q <= '0;
    else if (clr_stats)           err_count_q <= '0;
    else if (le_q | fe_q | to_q)  err_count_q <= sat_inc16(err_count_q);
  end

  assign err_count = err_count_q;
`endif

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign line_err    = le_q;
  assign frame_err   = fe_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench: two monitors (active-low and active-high sync) fed the same timing
// on a scaled-down raster; expected events are queued as stimulus is driven.
module tb_vga_timing_monitor;
  import vga_timing_pkg::*;

  localparam int HT  = 64;
  localparam int VT  = 10;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int VSW = V_SYNC_480;
  localparam int TOM = 2;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        fs;
    logic        le;
    logic        fe;
    logic        to;
    logic        lk;
  } snap_t;

  logic clk_25MHz = 1'b0;
  logic rst_n     = 1'b0;
  logic hsync     = 1'b1;
  logic vsync     = 1'b1;
  logic [15:0] xa, ya, xb, yb;
  logic fsa, lka, lea, fea, toa, fsb, lkb, leb, feb, tob;
`ifdef VGA_MON_STATS_EN
  logic clr_stats = 1'b0;
  logic [15:0] eca, ecb;
`endif

  snap_t exp_q[$];
  snap_t obs_q[2][$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1'b1),
                       .LOCK_FRAMES(2), .TIMEOUT_MULT(TOM)) dut_a (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .x_pos(xa), .y_pos(ya), .frame_start(fsa), .locked(lka),
    .line_err(lea), .frame_err(fea), .timeout(toa)
`ifdef VGA_MON_STATS_EN
    , .clr_stats(clr_stats), .err_count(eca)
`endif
  );

  vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1'b0),
                       .LOCK_FRAMES(2), .TIMEOUT_MULT(TOM)) dut_b (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .hsync(~hsync), .vsync(~vsync),
    .x_pos(xb), .y_pos(yb), .frame_start(fsb), .locked(lkb),
    .line_err(leb), .frame_err(feb), .timeout(tob)
`ifdef VGA_MON_STATS_EN
    , .clr_stats(clr_stats), .err_count(ecb)
`endif
  );

  // Capture the DUT whenever a line restarts or any pulse is present.
  always @(negedge clk_25MHz) begin
    if (mon_en && rst_n) begin
      if (xa == 16'd0 || fsa || lea || fea || toa) obs_q[0].push_back({xa, ya, fsa, lea, fea, toa, lka});
      if (xb == 16'd0 || fsb || leb || feb || tob) obs_q[1].push_back({xb, yb, fsb, leb, feb, tob, lkb});
    end
  end

  task automatic drive_line(input int gy, input int len, input snap_t e);
    for (int gx = 0; gx < len; gx++) begin
      @(negedge clk_25MHz);
      hsync = !(gx >= HFP && gx < HFP + HSW);
      vsync = !(gy < VSW);
      if (gx == HFP) exp_q.push_back(e);
    end
  endtask

  // short_ln: index of a line one clock short (-1 none); lk_exp: locked from frame start on.
  task automatic drive_frame(input int lines, input int short_ln, input bit fe_exp, input bit lk_exp);
    bit lk;
    bit le;
    snap_t e;
    lk = lk_exp;
    for (int gy = 0; gy < lines; gy++) begin
      le = (short_ln >= 0) && (gy == short_ln + 1);
      if (le) lk = 1'b0;
      e = {16'd0, 16'(gy), (gy == 0), le, (gy == 0) && fe_exp, 1'b0, lk};
      drive_line(gy, (gy == short_ln) ? HT - 1 : HT, e);
    end
  endtask

  task automatic release_reset();
    @(negedge clk_25MHz);
    rst_n = 1'b1;
    @(posedge clk_25MHz);
    #1 mon_en = 1'b1;
  endtask

  task automatic test_reset();
    logic [36:0] va, vb;
    repeat (3) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    va = {xa, ya, fsa, lka, lea, fea, toa};
    vb = {xb, yb, fsb, lkb, leb, feb, tob};
    n_cmp++;
    if (va !== 37'd0) begin n_bad++; $display("FAIL reset dut0: outputs %h expected 0", va); end
    n_cmp++;
    if (vb !== 37'd0) begin n_bad++; $display("FAIL reset dut1: outputs %h expected 0", vb); end
`ifdef VGA_MON_STATS_EN
    n_cmp++;
    if (eca !== 16'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d expected 0", eca); end
`endif
    release_reset();
  endtask

  task automatic test_nominal();
    snap_t e, o;
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_q[d].size() == 0) begin n_bad++; $display("FAIL nominal dut%0d: no event, expected %h", d, e); end
        else begin
          o = obs_q[d].pop_front();
          if (o !== e) begin n_bad++; $display("FAIL nominal dut%0d: got %h expected %h", d, o, e); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_q[d].size() != 0) begin
        n_bad++; $display("FAIL nominal_extra dut%0d: %0d extra events, expected 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
  endtask

  task automatic test_short_line();
    snap_t e, o;
    drive_frame(VT, 3, 1'b0, 1'b1);
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_q[d].size() == 0) begin n_bad++; $display("FAIL short_line dut%0d: no event, expected %h", d, e); end
        else begin
          o = obs_q[d].pop_front();
          if (o !== e) begin n_bad++; $display("FAIL short_line dut%0d: got %h expected %h", d, o, e); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_q[d].size() != 0) begin
        n_bad++; $display("FAIL short_line_extra dut%0d: %0d extra events, expected 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
  endtask

  task automatic test_short_frame();
    snap_t e, o;
    drive_frame(VT - 1, -1, 1'b0, 1'b1);
    drive_frame(VT, -1, 1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_q[d].size() == 0) begin n_bad++; $display("FAIL short_frame dut%0d: no event, expected %h", d, e); end
        else begin
          o = obs_q[d].pop_front();
          if (o !== e) begin n_bad++; $display("FAIL short_frame dut%0d: got %h expected %h", d, o, e); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_q[d].size() != 0) begin
        n_bad++; $display("FAIL short_frame_extra dut%0d: %0d extra events, expected 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
  endtask

  task automatic test_timeout();
    snap_t e, o;
    exp_q.push_back({16'(HT * TOM - 1), 16'(VT - 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (HT * TOM + 20) begin
      @(negedge clk_25MHz);
      hsync = 1'b1;
      vsync = 1'b1;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_q[d].size() == 0) begin n_bad++; $display("FAIL timeout dut%0d: no event, expected %h", d, e); end
        else begin
          o = obs_q[d].pop_front();
          if (o !== e) begin n_bad++; $display("FAIL timeout dut%0d: got %h expected %h", d, o, e); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_q[d].size() != 0) begin
        n_bad++; $display("FAIL timeout_extra dut%0d: %0d extra events, expected 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
`ifdef VGA_MON_STATS_EN
    n_cmp++;
    if (eca !== 16'd3 || ecb !== 16'd3) begin
      n_bad++; $display("FAIL err_count: got %0d/%0d expected 3", eca, ecb);
    end
    @(negedge clk_25MHz);
    clr_stats = 1'b1;
    @(negedge clk_25MHz);
    clr_stats = 1'b0;
    n_cmp++;
    if (eca !== 16'd0 || ecb !== 16'd0) begin
      n_bad++; $display("FAIL err_count_clear: got %0d/%0d expected 0", eca, ecb);
    end
`endif
  endtask

  task automatic test_polarity_relock();
    snap_t e, o;
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_q[d].size() == 0) begin n_bad++; $display("FAIL relock dut%0d: no event, expected %h", d, e); end
        else begin
          o = obs_q[d].pop_front();
          if (o !== e) begin n_bad++; $display("FAIL relock dut%0d: got %h expected %h", d, o, e); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_q[d].size() != 0) begin
        n_bad++; $display("FAIL relock_extra dut%0d: %0d extra events, expected 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
  endtask

  task automatic test_midline_reset();
    snap_t e, o;
    logic [36:0] va, vb;
    e = {16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_line(0, HFP + 31, e);
    @(negedge clk_25MHz);
    n_cmp++;
    if (xa !== 16'd30 || xb !== 16'd30) begin
      n_bad++; $display("FAIL midline_x: got %0d/%0d expected 30", xa, xb);
    end
    n_cmp++;
    if (lka !== 1'b1 || lkb !== 1'b1) begin
      n_bad++; $display("FAIL midline_locked: got %b/%b expected 1", lka, lkb);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    va = {xa, ya, fsa, lka, lea, fea, toa};
    vb = {xb, yb, fsb, lkb, leb, feb, tob};
    n_cmp++;
    if (va !== 37'd0 || vb !== 37'd0) begin
      n_bad++; $display("FAIL midline_reset: outputs %h/%h expected 0", va, vb);
    end
    repeat (2) @(posedge clk_25MHz);
    release_reset();
    drive_frame(VT, -1, 1'b0, 1'b0);
    drive_frame(VT, -1, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_q[d].size() == 0) begin n_bad++; $display("FAIL midline dut%0d: no event, expected %h", d, e); end
        else begin
          o = obs_q[d].pop_front();
          if (o !== e) begin n_bad++; $display("FAIL midline dut%0d: got %h expected %h", d, o, e); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_q[d].size() != 0) begin
        n_bad++; $display("FAIL midline_extra dut%0d: %0d extra events, expected 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_short_frame();
    test_timeout();
    test_polarity_relock();
    test_midline_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
